cpu_sequencer: RTL and testbench

Upstream issue stage for `cpu`. Accepts instruction words plus a 32-bit immediate through a valid/ready handshake and buffers them in a 4-entry FIFO. Decodes each entry into `cpu` control/address/data inputs and holds them for `HOLD_CYCLES` clocks. Samples `cpu` `outPut`/`over` at the end of each ALU or READ window and returns them as a one-cycle result.

---
 rtl/cpu_sequencer_pkg.sv | 83 ++++++++
 rtl/cpu_sequencer_if.sv | 22 ++
 rtl/cpu_sequencer_fifo.sv | 47 ++++
 rtl/cpu_sequencer.sv | 119 +++++++++++
 tb/tb_cpu_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sequencer_pkg.sv
// seq_pkg: shared encodings and decode helper for the cpu issue sequencer.
// Instruction word is {kind[15:14], sub[13], rsvd[12:10], rA[9:5], rB[4:0]}.
package seq_pkg;

  typedef enum logic [1:0] {
    KIND_STORE = 2'b00,
    KIND_ALU   = 2'b01,
    KIND_READ  = 2'b10,
    KIND_NOP   = 2'b11
  } kind_e;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OUT_REG = 2'b00;
  localparam logic [1:0] OUT_ALU = 2'b01;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

  localparam int KIND_HI = 15;
  localparam int KIND_LO = 14;
  localparam int SUB_BIT = 13;
  localparam int RA_HI   = 9;
  localparam int RA_LO   = 5;
  localparam int RB_HI   = 4;
  localparam int RB_LO   = 0;
  localparam int ENTRY_W = 48;

  typedef struct packed {
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [31:0] data;
    logic [1:0]  opsel;
    logic [1:0]  outsel;
    logic        asel;
    logic        bsel;
    logic        oen;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic ctrl_t decode(
    input kind_e       kind,
    input logic        sub,
    input logic [4:0]  ra,
    input logic [4:0]  rb,
    input logic [31:0] imm
  );
    ctrl_t c;
    c = CTRL_IDLE;
    unique case (1'b1)
      kind == KIND_STORE: begin
        c.addr_b = rb;
        c.data   = imm;
        c.opsel  = OP_SUB;
        c.outsel = OUT_REG;
        c.oen    = 1'b1;
      end
      kind == KIND_ALU: begin
        c.addr_a = ra;
        c.addr_b = rb;
        c.opsel  = {1'b0, sub};
        c.outsel = OUT_ALU;
        c.asel   = 1'b1;
        c.bsel   = 1'b1;
        c.oen    = 1'b1;
      end
      kind == KIND_READ: begin
        c.addr_a = ra;
        c.addr_b = ra;
        c.opsel  = OP_SUB;
        c.outsel = OUT_REG;
        c.asel   = 1'b1;
        c.oen    = 1'b1;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: valid/ready instruction handshake into the sequencer.
// Master offers {instr, imm}; slave returns ready while its buffer has room.
interface cpu_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [31:0] in_imm;

  modport master (
    output in_valid,
    output in_instr,
    output in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_instr,
    input  in_imm,
    output in_ready
  );
endinterface

// File: rtl/cpu_sequencer_fifo.sv
// seq_fifo: synchronous FIFO with occupancy counter and full/empty flags.
// Head entry is visible combinationally; push is dropped when full.
module seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: buffers instructions, drives cpu controls for fixed windows,
// and returns the cpu result sampled at the end of ALU/READ windows.
module cpu_sequencer
  import seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_sequencer_if.slave    in_bus,
  output logic [4:0]        addressA,
  output logic [4:0]        addressB,
  output logic [31:0]       dataIn,
  output logic [1:0]        opsel,
  output logic [1:0]        outsel,
  output logic              asel,
  output logic              bsel,
  output logic              oen,
  input  logic [31:0]       cpu_out,
  input  logic              cpu_over,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic              res_over,
  output logic              busy
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [ENTRY_W-1:0] w_entry;
  logic [15:0]        w_instr;
  logic [31:0]        w_imm;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_win_end;
  logic               w_unused;
  kind_e              w_kind;
  ctrl_t              w_next;

  state_e             r_state;
  ctrl_t              r_ctrl;
  kind_e              r_kind;
  logic [CW-1:0]      r_cnt;
  logic               r_res_valid;
  logic [31:0]        r_res_data;
  logic               r_res_over;

  seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_bus.in_valid),
    .i_pop   (w_pop),
    .i_data  ({in_bus.in_instr, in_bus.in_imm}),
    .o_data  (w_entry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_bus.in_ready = !w_full;
  assign w_instr   = w_entry[47:32];
  assign w_imm     = w_entry[31:0];
  assign w_unused  = ^w_instr[12:10];
  assign w_kind    = kind_e'(w_instr[KIND_HI:KIND_LO]);
  assign w_next    = decode(w_kind, w_instr[SUB_BIT],
                            w_instr[RA_HI:RA_LO],
                            w_instr[RB_HI:RB_LO], w_imm);
  assign w_win_end = (r_state == S_ISSUE) && (r_cnt == '0);
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || w_win_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ctrl      <= CTRL_IDLE;
      r_kind      <= KIND_NOP;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_over  <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_win_end && (r_kind == KIND_ALU || r_kind == KIND_READ)) begin
        r_res_valid <= 1'b1;
        r_res_data  <= cpu_out;
        r_res_over  <= cpu_over;
      end
      // a pop in either state starts a fresh window with the new decode
      if (w_pop) begin
        r_state <= S_ISSUE;
        r_ctrl  <= w_next;
        r_kind  <= w_kind;
        r_cnt   <= CW'(HOLD_CYCLES - 1);
      end else if (r_state == S_ISSUE) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_state <= S_IDLE;
          r_ctrl  <= CTRL_IDLE;
          r_kind  <= KIND_NOP;
        end
      end
    end
  end

  assign addressA  = r_ctrl.addr_a;
  assign addressB  = r_ctrl.addr_b;
  assign dataIn    = r_ctrl.data;
  assign opsel     = r_ctrl.opsel;
  assign outsel    = r_ctrl.outsel;
  assign asel      = r_ctrl.asel;
  assign bsel      = r_ctrl.bsel;
  assign oen       = r_ctrl.oen;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_over  = r_res_over;
  assign busy      = (r_state == S_ISSUE) || !w_empty;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: random stimulus against a cycle-level reference model
// of the issue schedule, with a small behavioural cpu register file attached.
module tb_cpu_sequencer;
  import seq_pkg::*;

  localparam int H    = 2;
  localparam int D    = 4;
  localparam int MAXN = 160;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if bus();

  logic [4:0]  addressA, addressB;
  logic [31:0] dataIn, cpu_out, res_data;
  logic [1:0]  opsel, outsel;
  logic        asel, bsel, oen, cpu_over;
  logic        res_valid, res_over, busy;

  cpu_sequencer #(
    .HOLD_CYCLES (H),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (bus),
    .addressA  (addressA),
    .addressB  (addressB),
    .dataIn    (dataIn),
    .opsel     (opsel),
    .outsel    (outsel),
    .asel      (asel),
    .bsel      (bsel),
    .oen       (oen),
    .cpu_out   (cpu_out),
    .cpu_over  (cpu_over),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_over  (res_over),
    .busy      (busy)
  );

  // behavioural cpu: register file, store write, add/sub with signed overflow
  logic [31:0] cregs [32] = '{default: 32'h0};
  logic [31:0] ca, cb, cs;

  always @(posedge clk) begin
    if (oen && !asel) cregs[addressB] <= dataIn;
  end

  always_comb begin
    ca = cregs[addressA];
    cb = cregs[addressB];
    cs = opsel[0] ? (ca - cb) : (ca + cb);
    cpu_out  = ca;
    cpu_over = 1'b0;
    if (outsel == OUT_ALU) begin
      cpu_out  = cs;
      cpu_over = opsel[0] ? ((ca[31] != cb[31]) && (cs[31] != ca[31]))
                          : ((ca[31] == cb[31]) && (cs[31] != ca[31]));
    end
  end

  logic [63:0] dut_ctrl;
  assign dut_ctrl = {15'b0, addressA, addressB, dataIn,
                     opsel, outsel, asel, bsel, oen};

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;
  int nacc    = 0;
  bit mon_en  = 1'b0;
  bit full_seen = 1'b0;

  int          acc_e    [MAXN];
  int          pop_e    [MAXN];
  logic [63:0] exp_ctrl [MAXN];
  bit          has_res  [MAXN];
  logic [31:0] exp_data [MAXN];
  bit          exp_ovf  [MAXN];
  logic [31:0] sh       [32];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [63:0] pk(
    input logic [4:0] a, input logic [4:0] b, input logic [31:0] d,
    input logic [1:0] op, input logic [1:0] os,
    input logic as_, input logic bs_, input logic oe);
    return {15'b0, a, b, d, op, os, as_, bs_, oe};
  endfunction

  function automatic logic [63:0] ref_ctrl(input logic [15:0] ins,
                                           input logic [31:0] imm);
    logic [4:0] ra, rb;
    ra = ins[9:5];
    rb = ins[4:0];
    case (ins[15:14])
      2'b00:   return pk(5'd0, rb, imm, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
      2'b01:   return pk(ra, rb, 32'd0, {1'b0, ins[13]}, 2'b01,
                         1'b1, 1'b1, 1'b1);
      2'b10:   return pk(ra, ra, 32'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
      default: return 64'd0;
    endcase
  endfunction

  // accepted on the coming edge n+1; window starts at the later of the
  // next edge and the end of the previous window
  task automatic record(input logic [15:0] ins, input logic [31:0] imm);
    int k, prev_end;
    longint ia, ib, full;
    logic [4:0] ra, rb;
    k  = nacc;
    ra = ins[9:5];
    rb = ins[4:0];
    acc_e[k] = n + 1;
    prev_end = (k == 0) ? 0 : pop_e[k-1] + H;
    pop_e[k] = (acc_e[k] + 1 > prev_end) ? acc_e[k] + 1 : prev_end;
    exp_ctrl[k] = ref_ctrl(ins, imm);
    has_res[k]  = 1'b0;
    exp_data[k] = 32'd0;
    exp_ovf[k]  = 1'b0;
    case (ins[15:14])
      2'b00: sh[rb] = imm;
      2'b01: begin
        ia = longint'($signed(sh[ra]));
        ib = longint'($signed(sh[rb]));
        full = ins[13] ? ia - ib : ia + ib;
        exp_data[k] = full[31:0];
        exp_ovf[k]  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
        has_res[k]  = 1'b1;
      end
      2'b10: begin
        exp_data[k] = sh[ra];
        has_res[k]  = 1'b1;
      end
      default: ;
    endcase
    nacc++;
  endtask

  task automatic check_cycle();
    logic [63:0] ec;
    logic [31:0] ed;
    bit ev, eo, inwin;
    int occ;
    ec = 64'd0; ed = 32'd0; ev = 0; eo = 0; inwin = 0; occ = 0;
    for (int k = 0; k < nacc; k++) begin
      if (acc_e[k] <= n) occ++;
      if (pop_e[k] <= n) occ--;
      if (pop_e[k] <= n && n < pop_e[k] + H) begin
        ec = exp_ctrl[k];
        inwin = 1;
      end
      if (has_res[k] && pop_e[k] + H <= n) begin
        ed = exp_data[k];
        eo = exp_ovf[k];
        ev = (pop_e[k] + H == n);
      end
    end
    if (!bus.in_ready) full_seen = 1'b1;
    chk("ctrl", dut_ctrl, ec);
    chk("res_valid", 64'(res_valid), 64'(ev));
    chk("res_data", 64'(res_data), 64'(ed));
    chk("res_over", 64'(res_over), 64'(eo));
    chk("busy", 64'(busy), 64'(inwin || occ > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(occ < D));
  endtask

  task automatic tick(output bit acc);
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (acc) record(bus.in_instr, bus.in_imm);
    @(posedge clk);
    n++;
    @(negedge clk);
    if (mon_en) check_cycle();
  endtask

  task automatic push(input logic [15:0] ins, input logic [31:0] imm);
    bit acc;
    int w;
    acc = 0;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_imm   = imm;
    while (!acc && w < 50) begin
      tick(acc);
      w++;
    end
    chk("push_accept", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic gap(input int c);
    bit acc;
    bus.in_valid = 1'b0;
    for (int i = 0; i < c; i++) tick(acc);
  endtask

  task automatic drain();
    int tgt;
    bit acc;
    bus.in_valid = 1'b0;
    tgt = (nacc == 0) ? n + 1 : pop_e[nacc-1] + H + 2;
    for (int g = 0; g < 400 && n < tgt; g++) tick(acc);
    chk("drain_done", 64'(n >= tgt), 64'd1);
  endtask

  function automatic logic [15:0] mk(input logic [1:0] kind,
                                     input logic sub,
                                     input logic [4:0] ra,
                                     input logic [4:0] rb);
    return {kind, sub, 3'b000, ra, rb};
  endfunction

  task automatic reset_model();
    n = 0;
    nacc = 0;
  endtask

  initial begin
    bit acc;
    logic [15:0] ins;
    for (int r = 0; r < 32; r++) sh[r] = 32'd0;
    bus.in_valid = 1'b0;
    bus.in_instr = 16'd0;
    bus.in_imm   = 32'd0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", dut_ctrl, 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    reset_model();
    mon_en = 1'b1;

    // reset mid-window aborts the STORE with no strobe
    push(mk(2'b00, 1'b0, 5'd0, 5'd0), 32'hFFFF_FFEF);
    tick(acc);
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("abort_ctrl", dut_ctrl, 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_res_data", 64'(res_data), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_res_valid", 64'(res_valid), 64'd0);
    end
    rst_n = 1'b1;
    reset_model();
    mon_en = 1'b1;

    // store sequence, back-to-back
    push(mk(2'b00, 1'b0, 5'd0, 5'd0),  32'hFFFF_FFEF);
    push(mk(2'b00, 1'b0, 5'd0, 5'd1),  32'h0000_0011);
    push(mk(2'b00, 1'b0, 5'd0, 5'd2),  32'h0000_0022);
    push(mk(2'b00, 1'b0, 5'd0, 5'd22), 32'h0000_0044);
    // ALU add, ALU sub, READ
    push(mk(2'b01, 1'b0, 5'd0, 5'd1),  32'hDEAD_BEEF);
    push(mk(2'b01, 1'b1, 5'd0, 5'd22), 32'h0);
    push(mk(2'b10, 1'b0, 5'd2, 5'd9),  32'h0);
    drain();
    chk("read_r2", 64'(res_data), 64'd34);

    // fill the FIFO behind a STORE window with NOPs
    full_seen = 1'b0;
    push(mk(2'b00, 1'b0, 5'd0, 5'd5), 32'h0000_0005);
    for (int i = 0; i < 8; i++) push(mk(2'b11, 1'b1, 5'd3, 5'd4), $urandom);
    drain();
    chk("full_seen", 64'(full_seen), 64'd1);

    // nine READs with random gaps wrap the pointers
    for (int i = 0; i < 9; i++) begin
      gap($urandom_range(0, 3));
      push(mk(2'b10, 1'b0, 5'($urandom_range(0, 31)), 5'd0), $urandom);
    end
    drain();

    // random mix of all kinds
    for (int i = 0; i < 30; i++) begin
      gap($urandom_range(0, 2));
      ins = 16'($urandom);
      push(ins, $urandom);
    end
    drain();
    chk("final_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
